cnn_ctrl: RTL and testbench
===========================

CNN_CTRL -- requirements
Module: cnn_ctrl

Interface
REQ-001 SHALL have parameter N_BEAT, default 75, meaning input beats per pattern (3 channels x 5x5 image).
REQ-002 SHALL have parameter N_KER, default 12, meaning beats carrying Kernel_ch1/Kernel_ch2 data.
REQ-003 SHALL have parameter N_WGT, default 24, meaning beats carrying Weight data.
REQ-004 SHALL have parameter WDOG, default 255, meaning maximum COMP cycles allowed without dp_done.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset; asynchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1, meaning a pattern input beat is present.
REQ-008 SHALL have port Opt, input, 1, meaning the option bit, valid on the first beat only.
REQ-009 SHALL have port dp_done, input, 1, meaning the datapath has finished computing.
REQ-010 SHALL have port busy, output, 1, meaning state is not IDLE.
REQ-011 SHALL have port img_ch, output, 2, meaning the image channel of the current beat.
REQ-012 SHALL have ports img_row and img_col, output, 3 each, meaning the pixel position of the current beat.
REQ-013 SHALL have ports ker_we, output, 1, and ker_idx, output, 4, meaning the kernel write enable and kernel slot.
REQ-014 SHALL have ports wgt_we, output, 1, and wgt_idx, output, 5, meaning the weight write enable and weight slot.
REQ-015 SHALL have port opt_q, output, 1, meaning the latched Opt.
REQ-016 SHALL have port dp_start, output, 1, meaning a one-cycle compute-start pulse.
REQ-017 SHALL have ports out_valid, output, 1, and out_sel, output, 2, meaning the result valid flag and result word select.
REQ-018 SHALL have port err, output, 1, meaning a one-cycle protocol-error pulse.

Function
REQ-019 SHALL implement states IDLE, LOAD, COMP and OUT, with registers for beat counter b (0..N_BEAT-1), watchdog counter (8 bit) and out counter (2 bit).
REQ-020 SHALL, in IDLE with in_valid=1, treat the cycle as beat 0, capture Opt into opt_q, set b to 1 and go to LOAD.
REQ-021 SHALL, in LOAD with in_valid=1, increment b; on beat N_BEAT-1 it SHALL clear b and go to COMP.
REQ-022 SHALL decode, combinationally and only when in_valid=1 in IDLE/LOAD: img_ch=b/25; img_row=(b%25)/5; img_col=b%5; ker_we=(b<N_KER) with ker_idx=b; wgt_we=(b<N_WGT) with wgt_idx=b.
REQ-023 SHALL drive ker_we, wgt_we, img_ch, img_row, img_col, ker_idx and wgt_idx to 0 whenever that in_valid condition is not met.
REQ-024 SHALL, in LOAD with in_valid=0 (early drop), pulse err the next cycle, clear b and go to IDLE.
REQ-025 SHALL register dp_start high for exactly the first COMP cycle, i.e. one cycle after the last beat.
REQ-026 SHALL sample dp_done in every COMP cycle, including the dp_start cycle; dp_done=1 SHALL move the state to OUT.
REQ-027 SHALL count COMP cycles in the watchdog; if WDOG cycles elapse without dp_done it SHALL pulse err and go to IDLE, with no out_valid.
REQ-028 SHALL, in OUT, hold out_valid=1 for exactly 3 consecutive cycles with out_sel=0,1,2, then go to IDLE.
REQ-029 SHALL, in the cycle after OUT ends, have out_valid=0 and busy=0; a new pattern MAY begin in that same cycle.
REQ-030 SHALL keep out_valid=0 outside OUT, and out_sel=0 whenever out_valid=0.
REQ-031 SHALL pulse err for one cycle when in_valid=1 arrives in COMP or OUT; the beat is ignored and the state sequence continues unchanged.
REQ-032 SHALL ignore dp_done outside COMP.
REQ-033 SHALL hold opt_q from the first beat until the next pattern's first beat.
REQ-034 SHALL register every output except the REQ-022 decodes.

Reset
REQ-035 SHALL, while rst=1, immediately force state IDLE, b=0, the watchdog and out counters to 0, and opt_q, dp_start, out_valid, out_sel, err and busy to 0, regardless of clk.
REQ-036 SHALL, when rst asserts mid-LOAD, mid-COMP or mid-OUT, abort the operation, emit no further out_valid, and require a fresh pattern starting at beat 0.

Verification
REQ-037 Nominal: Opt=1, 75 contiguous beats, dp_done 10 cycles after dp_start -> dp_start 1 cycle after beat 74; out_valid on 3 cycles with out_sel 0,1,2; opt_q=1; err never asserted.
REQ-038 Decode: beat 37 -> img_ch=1, img_row=2, img_col=2, ker_we=0, wgt_we=0; beat 11 -> ker_we=1, ker_idx=11; beat 23 -> wgt_we=1, wgt_idx=23; beat 24 -> wgt_we=0.
REQ-039 Early drop: in_valid low after beat 40 -> err pulses once; busy=0; the next full pattern completes normally.
REQ-040 Watchdog: dp_done held 0 -> err exactly 255 COMP cycles after entering COMP; out_valid never asserted.
REQ-041 Back-to-back with overlap checks: in_valid during OUT -> err pulse, while out_valid still completes 3 cycles; dp_done=1 in the dp_start cycle -> OUT on the next cycle.
REQ-042 Asynchronous reset: rst pulsed between clock edges during COMP -> all outputs 0 before the next edge; no out_valid follows.

Source files
------------

// File: rtl/cnn_ctrl.sv
// -----------------------------------------------------------------------------
// cnn_ctrl : sequencing controller for a small CNN datapath.
//
// One pattern is N_BEAT contiguous input beats (3 channels x 5x5 pixels). The
// controller decodes each beat into an image position and kernel/weight
// write slots, then starts the datapath, waits for dp_done under a watchdog,
// and presents three result words.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous, active-high reset
//   in_valid   : pattern input beat present
//   Opt        : option bit, meaningful on the first beat only
//   dp_done    : datapath finished (observed in COMP only)
//   busy       : registered, high whenever state is not IDLE
//   img_ch     : channel of the current beat            (combinational)
//   img_row    : pixel row of the current beat          (combinational)
//   img_col    : pixel column of the current beat       (combinational)
//   ker_we     : kernel write enable, ker_idx its slot  (combinational)
//   wgt_we     : weight write enable, wgt_idx its slot  (combinational)
//   opt_q      : Opt latched on the first beat of a pattern
//   dp_start   : one-cycle compute-start pulse (first COMP cycle)
//   out_valid  : result valid, three cycles; out_sel selects word 0,1,2
//   err        : one-cycle protocol error pulse
// -----------------------------------------------------------------------------
module cnn_ctrl #(
  parameter int N_BEAT = 75,
  parameter int N_KER  = 12,
  parameter int N_WGT  = 24,
  parameter int WDOG   = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       Opt,
  input  logic       dp_done,
  output logic       busy,
  output logic [1:0] img_ch,
  output logic [2:0] img_row,
  output logic [2:0] img_col,
  output logic       ker_we,
  output logic [3:0] ker_idx,
  output logic       wgt_we,
  output logic [4:0] wgt_idx,
  output logic       opt_q,
  output logic       dp_start,
  output logic       out_valid,
  output logic [1:0] out_sel,
  output logic       err
);

  localparam int BW = (N_BEAT > 1) ? $clog2(N_BEAT) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, COMP, OUT} state_t;

  state_t        state;
  logic [BW-1:0] b;         // beat index of the current beat (0 while IDLE)
  logic [7:0]    wdog_cnt;  // COMP cycles elapsed without dp_done
  logic [1:0]    out_cnt;   // result word being presented

  logic          beat_ok;
  logic [BW-1:0] pix;       // pixel number within the channel (b % 25)

  assign beat_ok = in_valid && (state == IDLE || state == LOAD);

  // Beat decode. In IDLE b is 0, so an accepted IDLE beat decodes as beat 0.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    img_ch  = '0;
    img_row = '0;
    img_col = '0;
    ker_we  = 1'b0;
    ker_idx = '0;
    wgt_we  = 1'b0;
    wgt_idx = '0;
    pix     = b % BW'(25);
    if (beat_ok) begin
      img_ch  = 2'(b / BW'(25));
      img_row = 3'(pix / BW'(5));
      img_col = 3'(b % BW'(5));
      ker_we  = (b < BW'(N_KER));
      wgt_we  = (b < BW'(N_WGT));
      // Slot indices are only meaningful alongside their write enable.
      ker_idx = ker_we ? 4'(b) : 4'd0;
      wgt_idx = wgt_we ? 5'(b) : 5'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      b         <= '0;
      wdog_cnt  <= '0;
      out_cnt   <= '0;
      opt_q     <= 1'b0;
      dp_start  <= 1'b0;
      out_valid <= 1'b0;
      out_sel   <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; pulse outputs default low
      // here and a later assignment in the same cycle overrides the default.
      dp_start <= 1'b0;
      err      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            opt_q <= Opt;
            b     <= BW'(1);
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (b == BW'(N_BEAT - 1)) begin
              b        <= '0;
              wdog_cnt <= '0;
              dp_start <= 1'b1;
              state    <= COMP;
            end else begin
              b <= b + BW'(1);
            end
          end else begin
            // Beats must be contiguous; a gap abandons the pattern.
            err   <= 1'b1;
            b     <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        COMP: begin
          if (in_valid) err <= 1'b1;
          if (dp_done) begin
            out_cnt   <= '0;
            out_sel   <= '0;
            out_valid <= 1'b1;
            state     <= OUT;
          end else if (wdog_cnt == 8'(WDOG - 1)) begin
            // This was the last allowed COMP cycle.
            err      <= 1'b1;
            wdog_cnt <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
          end else begin
            wdog_cnt <= wdog_cnt + 8'd1;
          end
        end
        OUT: begin
          if (in_valid) err <= 1'b1;
          if (out_cnt == 2'd2) begin
            out_cnt   <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
          end else begin
            out_cnt <= out_cnt + 2'd1;
            out_sel <= out_cnt + 2'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cnn_ctrl : self-checking bench for cnn_ctrl.
// Inputs change 1 ns after the rising edge; registered outputs are read at
// that point and combinational decodes 1 ns later.
// -----------------------------------------------------------------------------
module tb_cnn_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       Opt;
  logic       dp_done;
  logic       busy;
  logic [1:0] img_ch;
  logic [2:0] img_row;
  logic [2:0] img_col;
  logic       ker_we;
  logic [3:0] ker_idx;
  logic       wgt_we;
  logic [4:0] wgt_idx;
  logic       opt_q;
  logic       dp_start;
  logic       out_valid;
  logic [1:0] out_sel;
  logic       err;

  cnn_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .Opt(Opt), .dp_done(dp_done),
    .busy(busy), .img_ch(img_ch), .img_row(img_row), .img_col(img_col),
    .ker_we(ker_we), .ker_idx(ker_idx), .wgt_we(wgt_we), .wgt_idx(wgt_idx),
    .opt_q(opt_q), .dp_start(dp_start), .out_valid(out_valid),
    .out_sel(out_sel), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;
  int ov_seen  = 0;

  // Running tallies of err and out_valid cycles, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (err)       err_seen++;
      if (out_valid) ov_seen++;
    end
  end

  typedef struct {
    int         beat;
    logic [1:0] ch;
    logic [2:0] row;
    logic [2:0] col;
    logic       kwe;
    logic [3:0] kidx;
    logic       wwe;
    logic [4:0] widx;
  } dec_vec_t;

  localparam int NV = 7;
  dec_vec_t vec [NV];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_dec_zero(input string tag);
    check({tag, "_ch"},  32'(img_ch),  0);
    check({tag, "_row"}, 32'(img_row), 0);
    check({tag, "_col"}, 32'(img_col), 0);
    check({tag, "_kwe"}, 32'(ker_we),  0);
    check({tag, "_wwe"}, 32'(wgt_we),  0);
    check({tag, "_kidx"}, 32'(ker_idx), 0);
    check({tag, "_widx"}, 32'(wgt_idx), 0);
  endtask

  // Drive n contiguous beats; Opt is inverted after beat 0 to show that only
  // the first beat is captured.
  task automatic load(input logic opt, input int n, input bit tbl_chk);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      Opt      = (i == 0) ? opt : ~opt;
      #1;
      if (tbl_chk) begin
        for (int t = 0; t < NV; t++) begin
          if (vec[t].beat == i) begin
            check($sformatf("dec%0d_ch", i),  32'(img_ch),  32'(vec[t].ch));
            check($sformatf("dec%0d_row", i), 32'(img_row), 32'(vec[t].row));
            check($sformatf("dec%0d_col", i), 32'(img_col), 32'(vec[t].col));
            check($sformatf("dec%0d_kwe", i), 32'(ker_we),  32'(vec[t].kwe));
            check($sformatf("dec%0d_wwe", i), 32'(wgt_we),  32'(vec[t].wwe));
            if (vec[t].kwe)
              check($sformatf("dec%0d_kidx", i), 32'(ker_idx), 32'(vec[t].kidx));
            if (vec[t].wwe)
              check($sformatf("dec%0d_widx", i), 32'(wgt_idx), 32'(vec[t].widx));
          end
        end
      end
      tick();
    end
    in_valid = 1'b0;
    Opt      = 1'b0;
  endtask

  // Called in the first COMP cycle. dp_done is raised d cycles after
  // dp_start; inject puts a stray beat into the second OUT cycle.
  task automatic comp_out(input int d, input bit inject, input logic exp_opt);
    int e0;
    e0 = err_seen;
    check("c0_dp_start", 32'(dp_start), 1);
    check("c0_busy",     32'(busy),     1);
    check("c0_opt_q",    32'(opt_q),    32'(exp_opt));
    for (int k = 0; k <= d; k++) begin
      if (k > 0) begin
        tick();
        if (k == 1) check("dp_start_once", 32'(dp_start), 0);
        check("comp_no_ov", 32'(out_valid), 0);
      end
      if (k == d) dp_done = 1'b1;
    end
    tick();
    dp_done = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("out%0d_valid", j), 32'(out_valid), 1);
      check($sformatf("out%0d_sel", j),   32'(out_sel),   32'(j));
      check($sformatf("out%0d_busy", j),  32'(busy),      1);
      if (inject && j == 2) check("overlap_err", 32'(err), 1);
      if (inject && j == 1) begin
        in_valid = 1'b1;
        Opt      = ~exp_opt;
        #1;
        check("overlap_no_kwe", 32'(ker_we), 0);
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    Opt      = 1'b0;
    check("post_out_valid", 32'(out_valid), 0);
    check("post_out_sel",   32'(out_sel),   0);
    check("post_busy",      32'(busy),      0);
    check("post_opt_q",     32'(opt_q),     32'(exp_opt));
    check("err_count",      32'(err_seen - e0), inject ? 32'd1 : 32'd0);
  endtask

  initial begin
    int e0;
    int o0;
    //          beat ch row col kwe kidx wwe widx
    vec[0] = '{ 0,   0, 0,  0,  1,  0,   1,  0  };
    vec[1] = '{11,   0, 2,  1,  1,  11,  1,  11 };
    vec[2] = '{12,   0, 2,  2,  0,  0,   1,  12 };
    vec[3] = '{23,   0, 4,  3,  0,  0,   1,  23 };
    vec[4] = '{24,   0, 4,  4,  0,  0,   0,  0  };
    vec[5] = '{37,   1, 2,  2,  0,  0,   0,  0  };
    vec[6] = '{74,   2, 4,  4,  0,  0,   0,  0  };

    rst = 1'b1; in_valid = 1'b0; Opt = 1'b0; dp_done = 1'b0;
    #12;
    check("rst_busy",      32'(busy),      0);
    check("rst_opt_q",     32'(opt_q),     0);
    check("rst_dp_start",  32'(dp_start),  0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_sel",   32'(out_sel),   0);
    check("rst_err",       32'(err),       0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Nominal pattern with decode table, dp_done 10 cycles after dp_start.
    e0 = err_seen;
    load(1'b1, 75, 1'b1);
    #1;
    check_dec_zero("comp_idle_dec");
    comp_out(10, 1'b0, 1'b1);
    check("nominal_no_err", 32'(err_seen - e0), 0);

    // Early drop after beat 40, then a complete pattern.
    load(1'b1, 41, 1'b0);
    tick();
    check("drop_err",  32'(err),  1);
    check("drop_busy", 32'(busy), 0);
    tick();
    check("drop_err_once", 32'(err), 0);
    load(1'b0, 75, 1'b0);
    comp_out(4, 1'b0, 1'b0);

    // Watchdog: dp_done never arrives.
    load(1'b1, 75, 1'b0);
    e0 = err_seen;
    o0 = ov_seen;
    check("wdog_c0_dp_start", 32'(dp_start), 1);
    repeat (254) tick();
    check("wdog_not_early", 32'(err),  0);
    check("wdog_busy_held", 32'(busy), 1);
    tick();
    check("wdog_err",  32'(err),  1);
    check("wdog_idle", 32'(busy), 0);
    tick();
    check("wdog_err_once",  32'(err_seen - e0), 1);
    check("wdog_no_ov",     32'(ov_seen - o0),  0);

    // Back-to-back: dp_done in the dp_start cycle, stray beat in OUT, next
    // pattern beginning in the cycle right after OUT.
    load(1'b1, 75, 1'b0);
    comp_out(0, 1'b1, 1'b1);
    load(1'b0, 75, 1'b0);
    comp_out(2, 1'b0, 1'b0);

    // Asynchronous reset between edges in the first COMP cycle.
    load(1'b1, 75, 1'b0);
    check("ar_pre_dp_start", 32'(dp_start), 1);
    #2 rst = 1'b1;
    #1;
    check("ar_busy",      32'(busy),      0);
    check("ar_dp_start",  32'(dp_start),  0);
    check("ar_opt_q",     32'(opt_q),     0);
    check("ar_out_valid", 32'(out_valid), 0);
    check("ar_err",       32'(err),       0);
    #2 rst = 1'b0;
    dp_done = 1'b1;
    o0 = ov_seen;
    repeat (5) tick();
    dp_done = 1'b0;
    check("ar_stay_idle", 32'(busy),          0);
    check("ar_no_ov",     32'(ov_seen - o0), 0);
    load(1'b0, 75, 1'b0);
    comp_out(3, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
